// File: rtl/payload_checker_pkg.sv
// payload_checker_pkg: frame constants, FSM states and origin payload content shared by TX and RX.
package payload_checker_pkg;
    localparam int FRAME_LEN = 4320;
    localparam int ADDR_W = 13;
    localparam int TOT_W = 32;
    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
    // Origin payload: parity of a folded address under a fixed mask.
    function automatic logic payload_bit(input logic [ADDR_W-1:0] a);
        return ^((a ^ (a >> 5)) & 13'h1A6D);
    endfunction
endpackage

// File: rtl/payload_checker_rom.sv
// payload_rom: origin payload ROM, one bit wide with a registered 1-cycle read.
module payload_rom
    import payload_checker_pkg::*;
#(
    parameter int ADDR_W = payload_checker_pkg::ADDR_W
) (
    input  logic              clka,
    input  logic [ADDR_W-1:0] addra,
    output logic [0:0]        douta
);
    always_ff @(posedge clka) douta <= payload_bit(addra);
endmodule

// File: rtl/payload_checker.sv
// payload_checker: compares decoded payload bits against the origin ROM and keeps BER/FER totals.
module payload_checker
    import payload_checker_pkg::*;
#(
    parameter int FRAME_LEN = payload_checker_pkg::FRAME_LEN,
    parameter int ADDR_W = payload_checker_pkg::ADDR_W,
    parameter int TOT_W = payload_checker_pkg::TOT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_din,
    input  logic              i_din_vld,
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W-1:0] o_err_cnt,
    output logic              o_frame_err,
    output logic              o_overrun,
    output logic [TOT_W-1:0]  o_frm_total,
    output logic [TOT_W-1:0]  o_frm_bad,
    output logic [TOT_W-1:0]  o_bit_err_total
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_LEN - 1);
    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_wcnt;
    logic              r_din_d;
    logic              r_vld_d;
    logic              w_rom;
    logic              w_err;
    logic [ADDR_W-1:0] w_cnt_nxt;

    function automatic logic [TOT_W-1:0] sat_add(input logic [TOT_W-1:0] a, input logic [TOT_W-1:0] b);
        logic [TOT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[TOT_W] ? '1 : s[TOT_W-1:0];
    endfunction

    payload_rom #(.ADDR_W(ADDR_W)) u_rom (.clka(clk), .addra(r_addr), .douta(w_rom));

    // The compare result of the bit in flight is folded in combinationally so FLUSH can publish it.
    assign w_err = r_vld_d & (w_rom ^ r_din_d);
    assign w_cnt_nxt = r_wcnt + ADDR_W'(w_err);
    assign o_busy = (r_state == RUN) || (r_state == FLUSH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_addr <= '0;
            r_wcnt <= '0;
            r_din_d <= 1'b0;
            r_vld_d <= 1'b0;
            o_done <= 1'b0;
            o_err_cnt <= '0;
            o_frame_err <= 1'b0;
            o_overrun <= 1'b0;
            o_frm_total <= '0;
            o_frm_bad <= '0;
            o_bit_err_total <= '0;
        end else begin
            r_vld_d <= 1'b0;
            o_done <= 1'b0;
            r_wcnt <= w_cnt_nxt;
            if (i_din_vld && r_state != RUN) o_overrun <= 1'b1;
            if (i_start) begin
                r_state <= RUN;
                r_addr <= '0;
                r_wcnt <= '0;
                o_overrun <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: r_state <= IDLE;
                    RUN: begin
                        if (i_din_vld) begin
                            r_addr <= r_addr + 1'b1;
                            r_din_d <= i_din;
                            r_vld_d <= 1'b1;
                            r_state <= (r_addr == LAST) ? FLUSH : RUN;
                        end
                    end
                    FLUSH: begin
                        r_state <= DONE;
                        o_done <= 1'b1;
                        o_err_cnt <= w_cnt_nxt;
                        o_frame_err <= |w_cnt_nxt;
                        o_frm_total <= sat_add(o_frm_total, TOT_W'(1));
                        o_frm_bad <= sat_add(o_frm_bad, TOT_W'(|w_cnt_nxt));
                        o_bit_err_total <= sat_add(o_bit_err_total, TOT_W'(w_cnt_nxt));
                    end
                    DONE: r_state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_payload_checker.sv
// tb_payload_checker: directed frames with a done-triggered scoreboard monitor.
module tb_payload_checker;
    localparam int FRAME_LEN = 4320;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0;
    logic        i_din = 1'b0;
    logic        i_din_vld = 1'b0;
    logic        o_busy;
    logic        o_done;
    logic [12:0] o_err_cnt;
    logic        o_frame_err;
    logic        o_overrun;
    logic [31:0] o_frm_total;
    logic [31:0] o_frm_bad;
    logic [31:0] o_bit_err_total;

    typedef struct {
        int     cyc;
        int     err;
        int     ferr;
        longint tot;
        longint bad;
        longint bet;
    } exp_t;

    exp_t   q[$];
    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    bit     flip[FRAME_LEN];
    longint exp_tot = 0;
    longint exp_bad = 0;
    longint exp_bet = 0;

    payload_checker dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_din(i_din), .i_din_vld(i_din_vld),
        .o_busy(o_busy), .o_done(o_done), .o_err_cnt(o_err_cnt), .o_frame_err(o_frame_err),
        .o_overrun(o_overrun), .o_frm_total(o_frm_total), .o_frm_bad(o_frm_bad),
        .o_bit_err_total(o_bit_err_total)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic bit rom_bit(input int a);
        bit [12:0] x;
        bit [12:0] m;
        bit p;
        m = 13'h1A6D;
        x = 13'(a) ^ 13'(a >> 5);
        p = 1'b0;
        for (int k = 0; k < 13; k++) p ^= x[k] & m[k];
        return p;
    endfunction

    task automatic chk(input string n, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", n, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && o_done) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("done_cycle", cyc, e.cyc);
                chk("err_cnt", o_err_cnt, e.err);
                chk("frame_err", o_frame_err, e.ferr);
                chk("frm_total", o_frm_total, e.tot);
                chk("frm_bad", o_frm_bad, e.bad);
                chk("bit_err_total", o_bit_err_total, e.bet);
            end
        end
    end

    task automatic clear_flips();
        for (int i = 0; i < FRAME_LEN; i++) flip[i] = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        i_start = 1'b1;
        i_din_vld = 1'b0;
    endtask

    task automatic send(input int n, input bit gap, input int extra);
        int errs;
        exp_t e;
        errs = 0;
        for (int i = 0; i < n; i++) begin
            if (gap && i > 0) begin
                repeat ($urandom_range(1)) begin
                    @(posedge clk); #1;
                    i_start = 1'b0;
                    i_din_vld = 1'b0;
                end
            end
            @(posedge clk); #1;
            i_start = 1'b0;
            i_din_vld = 1'b1;
            i_din = rom_bit(i) ^ flip[i];
            errs += int'(flip[i]);
            if (i == FRAME_LEN - 1) begin
                exp_tot++;
                exp_bad += (errs != 0) ? 1 : 0;
                exp_bet += errs;
                e.cyc = cyc + 2;
                e.err = errs;
                e.ferr = (errs != 0) ? 1 : 0;
                e.tot = exp_tot;
                e.bad = exp_bad;
                e.bet = exp_bet;
                q.push_back(e);
            end
        end
        repeat (extra) begin
            @(posedge clk); #1;
            i_din_vld = 1'b1;
            i_din = 1'($urandom_range(1));
        end
        @(posedge clk); #1;
        i_din_vld = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && q.size() != 0; k++) @(posedge clk);
        repeat (3) @(posedge clk);
        chk("drain", q.size(), 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        clear_flips();
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_err_cnt", o_err_cnt, 0);
        chk("rst_overrun", o_overrun, 0);
        chk("rst_frm_total", o_frm_total, 0);

        pulse_start();
        send(FRAME_LEN, 1'b0, 0);
        drain();

        flip[0] = 1'b1;
        flip[2000] = 1'b1;
        flip[4319] = 1'b1;
        pulse_start();
        send(FRAME_LEN, 1'b0, 0);
        drain();
        clear_flips();

        pulse_start();
        send(FRAME_LEN, 1'b0, 0);
        drain();

        pulse_start();
        send(FRAME_LEN, 1'b1, 0);
        drain();

        pulse_start();
        send(1000, 1'b0, 0);
        chk("abort_busy", o_busy, 1);
        pulse_start();
        send(FRAME_LEN, 1'b0, 0);
        drain();

        pulse_start();
        send(FRAME_LEN, 1'b0, 5);
        drain();
        chk("overrun_set", o_overrun, 1);
        chk("overrun_err_cnt", o_err_cnt, 0);
        chk("overrun_frm_total", o_frm_total, exp_tot);
        pulse_start();
        @(posedge clk); #1;
        i_start = 1'b0;
        chk("overrun_cleared", o_overrun, 0);
        chk("run_busy", o_busy, 1);

        send(2500, 1'b0, 0);
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy", o_busy, 0);
        chk("midrst_done", o_done, 0);
        chk("midrst_err_cnt", o_err_cnt, 0);
        chk("midrst_frame_err", o_frame_err, 0);
        chk("midrst_overrun", o_overrun, 0);
        chk("midrst_frm_total", o_frm_total, 0);
        chk("midrst_frm_bad", o_frm_bad, 0);
        chk("midrst_bit_err_total", o_bit_err_total, 0);
        exp_tot = 0;
        exp_bad = 0;
        exp_bet = 0;
        @(negedge clk) rst = 1'b0;

        flip[100] = 1'b1;
        pulse_start();
        send(FRAME_LEN, 1'b0, 0);
        drain();
        chk("idle_busy", o_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
